multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL provide ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- instruction  input  32  current IR contents; opcode [31:26], funct [5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completion for the current access.
- state  output  3  current FSM state encoding.
- pc_write  output  1  PC load strobe.
- npc_sel  output  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target.
- ir_write  output  1  IR load strobe.
- i_or_d  output  1  memory address source: 0 PC, 1 ALU result.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- alu_src  output  1  ALU B operand: 0 register, 1 immediate.
- alu_ctl  output  4  ALU op: 0 add, 1 sub, 3 or, 4 compare (beq), 5 lui.
- reg_dst  output  1  write register: 1 rd, 0 rt.
- mem_to_reg  output  1  writeback source: 1 memory, 0 ALU.
- reg_write  output  1  register file write strobe.
- illegal  output  1  unsupported opcode halt indicator.
- retired  output  CNT_W  count of completed instructions.

Function
REQ-003 SHALL decode addu (op 00, funct 21), subu (op 00, funct 23), ori (0d), lw (23), sw (2b), beq (04), lui (0f) and j (02); anything else is illegal.
REQ-004 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5 in a registered state; encodings 6 and 7 SHALL go to FETCH.
REQ-005 SHALL make all strobes combinational from state, instruction, zero and mem_ready; each strobe is 0 unless listed for the current state.
REQ-006 FETCH:
- Drive mem_read=1 and i_or_d=0.
- Hold FETCH while mem_ready=0.
- On mem_ready=1, assert ir_write=1 and pc_write=1 with npc_sel=00, then go to DECODE.
- Strobes in FETCH SHALL NOT depend on instruction.
REQ-007 DECODE:
- j: pc_write=1, npc_sel=10, go to FETCH.
- Illegal opcode: handled per REQ-015.
- All others: go to EXEC.
REQ-008 EXEC:
- Drive alu_src=1 for lw, sw, ori and lui.
- Drive alu_ctl: 0 for lw, sw and addu; 1 for subu; 3 for ori; 4 for beq; 5 for lui.
- beq: pc_write=zero, npc_sel=01, go to FETCH.
- lw and sw: go to MEM.
- addu, subu, ori and lui: go to WB.
REQ-009 MEM:
- Drive i_or_d=1, alu_ctl=0, alu_src=1, and mem_read=1 (lw) or mem_write=1 (sw).
- Hold MEM with the request steady while mem_ready=0.
- On mem_ready=1: sw goes to FETCH; lw goes to WB.
REQ-010 WB:
- Drive reg_write=1 for exactly one cycle.
- Drive reg_dst=1 for addu/subu, else 0.
- Drive mem_to_reg=1 for lw only.
- Go to FETCH.
REQ-011 SHALL increment retired (wrapping modulo 2^CNT_W) on every transition into FETCH from DECODE, EXEC, MEM or WB.
REQ-012 Latency in cycles, with zero-wait memory: j 2; beq 3; R-type, ori and lui 4; sw 4; lw 5. Each mem_ready=0 cycle adds one.
REQ-013 mem_ready=1 outside FETCH and MEM SHALL be ignored.

Reset
REQ-014 While rst=1:
- All strobes, illegal and npc_sel SHALL be forced to 0, in any state including mid-MEM.
- The next state SHALL be FETCH and retired SHALL be 0.
- The first fetch SHALL begin in the cycle after rst falls.

Configuration
REQ-015 Macro ILLEGAL_TRAP_EN:
- Defined: an illegal opcode in DECODE goes to HALT with no retire count. HALT holds, with illegal=1 and all strobes 0, until rst.
- Undefined: an illegal opcode is a NOP. DECODE goes to FETCH and increments retired. HALT is unreachable and illegal is tied to 0.

Verification
REQ-016 Reset then addu (0x00221821), mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 and reg_dst=1 in cycle 4 only; retired=1.
REQ-017 lw (0x8C220004) with mem_ready low for 3 MEM cycles -> mem_read and i_or_d held 4 MEM cycles; WB has mem_to_reg=1; total 8 cycles.
REQ-018 beq (0x10220003) with zero=1, then zero=0 -> pc_write=1/npc_sel=01 in EXEC for the first only; both retire.
REQ-019 Opcode 0x3F: with ILLEGAL_TRAP_EN -> state=5, illegal=1 held 10 cycles, retired unchanged. Without it -> back to FETCH, retired+1.
REQ-020 rst asserted during MEM of sw -> mem_write=0 that cycle; state=0 and retired=0 next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: combinational strobes from state/IR/flags, registered state and retire count.
// Optional ILLEGAL_TRAP_EN: unsupported opcodes halt in HALT until reset; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic [1:0]       npc_sel,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [3:0]       alu_ctl,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [5:0] op, funct;
  logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_rtype, is_legal;
  logic unused_bits;

  assign op          = instruction[31:26];
  assign funct       = instruction[5:0];
  assign unused_bits = ^instruction[25:6];

  assign is_addu  = (op == 6'h00) && (funct == 6'h21);
  assign is_subu  = (op == 6'h00) && (funct == 6'h23);
  assign is_ori   = (op == 6'h0d);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2b);
  assign is_beq   = (op == 6'h04);
  assign is_lui   = (op == 6'h0f);
  assign is_j     = (op == 6'h02);
  assign is_rtype = is_addu || is_subu;
  assign is_legal = is_rtype || is_ori || is_lw || is_sw || is_beq || is_lui || is_j;

  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    pc_write   = 1'b0;
    npc_sel    = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_ctl    = 4'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_write = 1'b1;
          npc_sel  = 2'b10;
          state_d  = S_FETCH;
        end else if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src = is_lw || is_sw || is_ori || is_lui;
        if (is_subu)     alu_ctl = 4'd1;
        else if (is_ori) alu_ctl = 4'd3;
        else if (is_beq) alu_ctl = 4'd4;
        else if (is_lui) alu_ctl = 4'd5;
        if (is_beq) begin
          pc_write = zero;
          npc_sel  = 2'b01;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_rtype || is_ori || is_lui) begin
          state_d = S_WB;
        end else begin
          // IR is not expected to change after DECODE; recover rather than wedge.
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src   = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready || !(is_lw || is_sw)) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if ((state_d == S_FETCH) &&
        ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)))
      retired_d = retired_q + CNT_W'(1);

    if (rst) begin
      state_d    = S_FETCH;
      retired_d  = '0;
      pc_write   = 1'b0;
      npc_sel    = 2'b00;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_ctl    = 4'd0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Vector-table bench for multicycle_ctrl with an expected-output scoreboard queue.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        zero, mem_ready;
  logic [2:0]  state;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, alu_src;
  logic [1:0]  npc_sel;
  logic [3:0]  alu_ctl;
  logic        reg_dst, mem_to_reg, reg_write, illegal;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .npc_sel(npc_sel), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .alu_ctl(alu_ctl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic [1:0]  npc;
    logic        irw, iod, mr, mw, as;
    logic [3:0]  alu;
    logic        rd, m2r, rw, ill;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic        r;
    logic [31:0] ins;
    logic        z;
    logic        rdy;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] ADDU = 32'h00221821, SUBU = 32'h00221823, ORI = 32'h34220005;
  localparam logic [31:0] LUI  = 32'h3C020005, LW   = 32'h8C220004, SW  = 32'hAC220004;
  localparam logic [31:0] BEQ  = 32'h10220003, JMP  = 32'h08000010, ILL = 32'hFC000000;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic exp_t E(input logic [2:0] st, input logic pcw, input logic [1:0] npc,
                             input logic irw, iod, mr, mw, as, input logic [3:0] alu,
                             input logic rd, m2r, rw, ill, input int ret);
    exp_t e;
    e = '{st:st, pcw:pcw, npc:npc, irw:irw, iod:iod, mr:mr, mw:mw, as:as,
          alu:alu, rd:rd, m2r:m2r, rw:rw, ill:ill, ret:32'(ret)};
    return e;
  endfunction

  function automatic exp_t fetch(input logic rdy, input int ret);
    return E(3'd0, rdy, 2'b00, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ret);
  endfunction

  function automatic exp_t idle(input logic [2:0] st, input int ret);
    return E(st, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ret);
  endfunction

  task automatic add(input logic r, input logic [31:0] ins, input logic z, input logic rdy, input exp_t e);
    vec_t v;
    v.r = r; v.ins = ins; v.z = z; v.rdy = rdy; v.e = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the edge, compare combinational outputs on the falling edge.
  task automatic step(input string name, input logic r, input logic [31:0] ins,
                      input logic z, input logic rdy, input exp_t e);
    exp_t got, want;
    rst = r; instruction = ins; zero = z; mem_ready = rdy;
    sb.push_back(e);
    @(negedge clk);
    got = '{st:state, pcw:pc_write, npc:npc_sel, irw:ir_write, iod:i_or_d, mr:mem_read,
            mw:mem_write, as:alu_src, alu:alu_ctl, rd:reg_dst, m2r:mem_to_reg,
            rw:reg_write, ill:illegal, ret:retired};
    want = sb.pop_front();
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got st=%0d pcw=%b npc=%b irw=%b iod=%b mr=%b mw=%b as=%b alu=%0d rd=%b m2r=%b rw=%b ill=%b ret=%0d, want st=%0d pcw=%b npc=%b irw=%b iod=%b mr=%b mw=%b as=%b alu=%0d rd=%b m2r=%b rw=%b ill=%b ret=%0d",
                  name, got.st, got.pcw, got.npc, got.irw, got.iod, got.mr, got.mw, got.as, got.alu,
                  got.rd, got.m2r, got.rw, got.ill, got.ret,
                  want.st, want.pcw, want.npc, want.irw, want.iod, want.mr, want.mw, want.as, want.alu,
                  want.rd, want.m2r, want.rw, want.ill, want.ret);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instruction = ADDU; zero = 1'b0; mem_ready = 1'b1;

    add(1, ADDU, 0, 1, idle(3'd0, 0));                                    // reset state
    // addu: 0,1,2,4
    add(0, ADDU, 0, 1, fetch(1, 0));
    add(0, ADDU, 0, 1, idle(3'd1, 0));
    add(0, ADDU, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    add(0, ADDU, 0, 1, E(3'd4, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 1, 0, 1, 0, 0));
    // lw with three wait cycles in MEM
    add(0, LW, 0, 1, fetch(1, 1));
    add(0, LW, 0, 1, idle(3'd1, 1));
    add(0, LW, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      add(0, LW, 0, (i == 3), E(3'd3, 0, 2'b00, 0, 1, 1, 0, 1, 4'd0, 0, 0, 0, 0, 1));
    add(0, LW, 0, 1, E(3'd4, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 1));
    // beq taken (with a fetch wait), then not taken
    add(0, BEQ, 1, 0, fetch(0, 2));
    add(0, BEQ, 1, 1, fetch(1, 2));
    add(0, BEQ, 1, 1, idle(3'd1, 2));
    add(0, BEQ, 1, 1, E(3'd2, 1, 2'b01, 0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 0, 2));
    add(0, BEQ, 0, 1, fetch(1, 3));
    add(0, BEQ, 0, 1, idle(3'd1, 3));
    add(0, BEQ, 0, 1, E(3'd2, 0, 2'b01, 0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 0, 3));
    // ori, with mem_ready low outside FETCH/MEM having no effect
    add(0, ORI, 0, 1, fetch(1, 4));
    add(0, ORI, 0, 0, idle(3'd1, 4));
    add(0, ORI, 0, 0, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 1, 4'd3, 0, 0, 0, 0, 4));
    add(0, ORI, 0, 0, E(3'd4, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 4));
    // lui
    add(0, LUI, 0, 1, fetch(1, 5));
    add(0, LUI, 0, 1, idle(3'd1, 5));
    add(0, LUI, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 0, 5));
    add(0, LUI, 0, 1, E(3'd4, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 5));
    // subu
    add(0, SUBU, 0, 1, fetch(1, 6));
    add(0, SUBU, 0, 1, idle(3'd1, 6));
    add(0, SUBU, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 6));
    add(0, SUBU, 0, 1, E(3'd4, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 1, 0, 1, 0, 6));
    // j: two cycles
    add(0, JMP, 0, 1, fetch(1, 7));
    add(0, JMP, 0, 1, E(3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 7));
    // sw zero-wait
    add(0, SW, 0, 1, fetch(1, 8));
    add(0, SW, 0, 1, idle(3'd1, 8));
    add(0, SW, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 8));
    add(0, SW, 0, 1, E(3'd3, 0, 2'b00, 0, 1, 0, 1, 1, 4'd0, 0, 0, 0, 0, 8));
    // illegal opcode reaches DECODE
    add(0, ILL, 0, 1, fetch(1, 9));
    add(0, ILL, 0, 1, idle(3'd1, 9));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].ins, vecs[i].z, vecs[i].rdy, vecs[i].e);

`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step($sformatf("halt%0d", i), 0, ILL, 0, 1,
           E(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 9));
`else
    step("ill_nop_fetch", 0, ILL, 0, 0, fetch(0, 10));
    step("ill_nop_fetch2", 0, ILL, 0, 0, fetch(0, 10));
`endif

    // Reset asserted mid-MEM of sw: strobes drop that cycle, counter clears next cycle.
    rst = 1'b1; instruction = JMP; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("rst_fetch_first", 0, JMP, 0, 1, fetch(1, 0));
    step("rst_j_dec", 0, JMP, 0, 1, E(3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    step("rst_sw_fetch", 0, SW, 0, 1, fetch(1, 1));
    step("rst_sw_dec", 0, SW, 0, 1, idle(3'd1, 1));
    step("rst_sw_exec", 0, SW, 0, 1, E(3'd2, 0, 2'b00, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 1));
    step("rst_sw_mem_wait", 0, SW, 0, 0, E(3'd3, 0, 2'b00, 0, 1, 0, 1, 1, 4'd0, 0, 0, 0, 0, 1));
    step("rst_in_mem", 1, SW, 0, 1, idle(3'd3, 1));
    step("rst_after", 0, SW, 0, 1, fetch(1, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
